block_serializer: RTL
=====================

BLOCK_SERIALIZER -- requirements
Module: block_serializer

Interface
REQ-001 The block SHALL have parameter BLK_BYTES, default 16, giving the number of bytes per block (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the main clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port blk_in, input, 8*BLK_BYTES bits: the parallel block to be sent.
REQ-005 The block SHALL have port blk_valid, input, 1 bit: blk_in is valid.
REQ-006 The block SHALL have port blk_ready, output, 1 bit: the block can accept blk_in this cycle.
REQ-007 The block SHALL have port byte_out, output, 8 bits: the current output byte.
REQ-008 The block SHALL have port byte_valid, output, 1 bit: byte_out is valid.
REQ-009 The block SHALL have port byte_ready, input, 1 bit: the downstream side accepts byte_out.
REQ-010 The block SHALL have port byte_last, output, 1 bit: byte_out is the final byte of the block.
REQ-011 The block SHALL have port busy, output, 1 bit: a block is in progress (high in SEND).

Function
REQ-012 The FSM SHALL have two states:
- IDLE: byte_valid=0, blk_ready=1.
- SEND: byte_valid=1.
REQ-013 A block SHALL be accepted when blk_valid and blk_ready are both high on a clock edge; blk_in is captured into the shift register, the byte counter clears to 0, and the FSM enters SEND.
REQ-014 Latency SHALL be one cycle: byte_valid rises on the cycle after acceptance and byte_out equals blk_in[8*BLK_BYTES-1 -: 8].
REQ-015 Bytes SHALL be sent MSB-first: byte k carries blk_in bits [8*(BLK_BYTES-k)-1 -: 8].
REQ-016 A byte SHALL transfer when byte_valid and byte_ready are both high on an edge; the shift register then shifts left by 8 bits (zero fill) and the counter increments.
REQ-017 byte_out SHALL be taken directly from the shift register top byte (registered, no combinational path from inputs).
REQ-018 While byte_valid=1 and byte_ready=0, byte_out, byte_last and the counter SHALL hold stable.
REQ-019 byte_last SHALL be high exactly when the FSM is in SEND and the counter equals BLK_BYTES-1.
REQ-020 When the last byte transfers, the FSM SHALL return to IDLE unless a new block is accepted in the same cycle.
REQ-021 blk_ready SHALL be asserted in IDLE, or in SEND when byte_last and byte_ready are both high; this combinational path from byte_ready is allowed and intended.
REQ-022 On a simultaneous last-byte transfer and new-block accept, the FSM SHALL stay in SEND, load the new block, clear the counter, and keep byte_valid high with no bubble.
REQ-023 In SEND with no last transfer, blk_ready SHALL be 0 and blk_in SHALL be ignored.
REQ-024 The counter SHALL be $clog2(BLK_BYTES) bits wide and SHALL never exceed BLK_BYTES-1 (no wrap within a block).

Reset
REQ-025 While reset is high on an edge, the block SHALL set FSM=IDLE, counter=0, shift register=0 and byte_valid=0, giving byte_out=8'h00, byte_last=0, busy=0 and blk_ready=1 after the edge.
REQ-026 A reset asserted mid-block SHALL drop the block; no further bytes of that block are emitted.
REQ-027 Reset SHALL take priority over any handshake in the same cycle.

Configuration
REQ-028 With macro SER_ZEROIZE_EN defined, the shift register SHALL be cleared to all zeros on the edge where the last byte transfers, unless a new block is loaded on that edge.
REQ-029 With SER_ZEROIZE_EN not defined, the shift register SHALL keep the left-shifted (zero-filled) residue after the final byte.
REQ-030 All port-visible behaviour SHALL be identical in both configurations.

Structure
REQ-031 The shared package aes_pkg SHALL hold the BLK_BYTES default constant (16) and the FSM state typedef ser_state_t {IDLE, SEND}.
REQ-032 The block SHALL be a single module with no sub-module; the shift register is local because it must shift, so buffer is not reused.

Verification
REQ-033 Load blk_in=128'h69c4e0d86a7b0430d8cdb78070b4c55a with byte_ready always 1 -> bytes 69,c4,e0,...,c5,5a on 16 consecutive cycles starting 1 cycle after accept; byte_last only on 5a.
REQ-034 Same block with byte_ready toggling 1,0,1,0 -> each byte is held stable while byte_ready=0; the order is unchanged and exactly 16 transfers occur.
REQ-035 Two blocks, with blk_valid held high and the second = 128'h00112233445566778899aabbccddeeff -> 00 follows 5a on the next cycle with no idle gap; blk_ready pulses only on the last-byte cycle.
REQ-036 Assert reset after the 5th byte -> next cycle byte_valid=0, byte_out=00, busy=0, blk_ready=1; a new block then starts again from byte 0.
REQ-037 With SER_ZEROIZE_EN defined, after the last byte with no new block -> the internal shift register is all zeros; port traces match the non-zeroize build.
REQ-038 Set BLK_BYTES=2 and load 16'hbeef -> bytes be, ef; byte_last on ef; FSM back to IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the block serializer: the default block size
// and the two-state FSM encoding.
package aes_pkg;

  // Default number of bytes per block (one 128-bit AES block).
  localparam int BLK_BYTES_DEF = 16;

  // IDLE waits for a block; SEND streams it out byte by byte.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/block_serializer.sv
// block_serializer: takes a BLK_BYTES-wide parallel block and streams it
// out MSB-first, one byte per valid/ready handshake. A new block may be
// accepted on the same edge the final byte leaves, giving gapless output.
//
// Build option: define SER_ZEROIZE_EN to clear the shift register on the
// edge where the final byte transfers (when no new block is loaded).
// Port-visible behaviour is the same with or without it.
module block_serializer
  import aes_pkg::*;
#(
  parameter int BLK_BYTES = BLK_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*BLK_BYTES-1:0] blk_in,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   byte_last,
  output logic                   busy
);

  localparam int W  = 8 * BLK_BYTES;
  localparam int CW = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLK_BYTES - 1);

  ser_state_t    state_reg;
  ser_state_t    state_next;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  shreg_reg;

  logic accept;
  logic xfer;

  assign accept = blk_valid & blk_ready;
  assign xfer   = byte_valid & byte_ready;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: leave SEND only when the last byte goes out and no
  // new block is taken on that same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer && byte_last && !accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and counter; blk_ready also looks at
  // byte_ready so a follow-on block can load with no bubble.
  always_comb begin
    byte_valid = (state_reg == SEND);
    busy       = (state_reg == SEND);
    byte_last  = (state_reg == SEND) && (cnt_reg == LAST_CNT);
    blk_ready  = (state_reg == IDLE) || (byte_last && byte_ready);
  end

  // Output byte comes straight from the top of the shift register.
  assign byte_out = shreg_reg[W-1 -: 8];

  // Shift register and byte counter: load on accept, shift on transfer,
  // hold otherwise. The counter clears after the final byte so it never
  // exceeds BLK_BYTES-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      shreg_reg <= blk_in;
      cnt_reg   <= '0;
    end else if (xfer) begin
      if (byte_last) begin
`ifdef SER_ZEROIZE_EN
        shreg_reg <= '0;
`else
        shreg_reg <= {shreg_reg[W-9:0], 8'h00};
`endif
        cnt_reg   <= '0;
      end else begin
        shreg_reg <= {shreg_reg[W-9:0], 8'h00};
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

endmodule
